// File: rtl/light_return.sv
// Far-end responder of the light-passing chain: opens a timed hit window when
// the light arrives and returns it on a timely key press, scoring hits and misses.
module light_return #(
    parameter int WINDOW = 4,
    parameter int CNT_W  = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             arrive,
    input  logic             key,
    output logic             ret,
    output logic             window_led,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int TW = $clog2(WINDOW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WINDOW = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic             key_d;
    logic             press, hit, miss;
    logic [CNT_W-1:0] hits_nx, misses_nx;
    logic             ret_nx, window_led_nx, done_nx;

    // key_d resets high so a key held through Reset never looks like a fresh press.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            key_d      <= 1'b1;
            hits       <= '0;
            misses     <= '0;
            ret        <= 1'b0;
            window_led <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            key_d      <= key;
            hits       <= hits_nx;
            misses     <= misses_nx;
            ret        <= ret_nx;
            window_led <= window_led_nx;
            done       <= done_nx;
        end
    end

    always_comb begin
        press     = key & ~key_d;
        hit       = (state == S_WINDOW) && press;
        miss      = (state == S_WINDOW) && !press && (timer == '0);
        hits_nx   = hits;
        misses_nx = misses;
        timer_nx  = timer;
        state_nx  = state;
        if (hit)  hits_nx   = hits + CNT_W'(1);
        if (miss) misses_nx = misses + CNT_W'(1);
        case (state)
            S_IDLE: begin
                if (arrive) begin
                    state_nx = S_WINDOW;
                    timer_nx = TW'(WINDOW - 1);
                end
            end
            S_WINDOW: begin
                // A press on the last window cycle still wins over expiry.
                if (hit || miss) begin
                    if (hits_nx == CNT_MAX || misses_nx == CNT_MAX)
                        state_nx = S_DONE;
                    else
                        state_nx = S_IDLE;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ret_nx        = hit;
        window_led_nx = (state_nx == S_WINDOW);
        done_nx       = (state_nx == S_DONE);
        dbg_state     = state;
    end

endmodule
